// File: rtl/serial_byte_subtractor_if.sv
// Byte-stream bundle for serial_byte_subtractor.
// Subtract only exists when SERIAL_ADDSUB_MODE_EN is defined.
interface serial_byte_subtractor_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       borrow_in;
`ifdef SERIAL_ADDSUB_MODE_EN
  logic       subtract;
`endif
  logic       out_valid;
  logic       out_ready;
  logic [7:0] difference;
  logic       out_last;
  logic       borrow_out;
  logic       zero;
  logic       overflow;

  modport master (
`ifdef SERIAL_ADDSUB_MODE_EN
    output subtract,
`endif
    output in_valid, a, b, borrow_in, out_ready,
    input  in_ready, out_valid, difference,
    input  out_last, borrow_out, zero, overflow
  );

  modport slave (
`ifdef SERIAL_ADDSUB_MODE_EN
    input  subtract,
`endif
    input  in_valid, a, b, borrow_in, out_ready,
    output in_ready, out_valid, difference,
    output out_last, borrow_out, zero, overflow
  );
endinterface

// File: rtl/serial_byte_subtractor.sv
// Byte-serial multi-precision A - B - borrow, LSB first.
// SERIAL_ADDSUB_MODE_EN adds a per-operation add/subtract select.
module serial_byte_subtractor #(
  parameter int WORD_BYTES = 4
) (
  input logic clk,
  input logic rst,
  serial_byte_subtractor_if.slave s
);

  localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  logic [IW-1:0] idx;
  logic          brw;
  logic          zacc;
`ifdef SERIAL_ADDSUB_MODE_EN
  logic          sub_q;
`endif

  logic       ov_q;
  logic [7:0] d_q;
  logic       last_q;
  logic       bo_q;
  logic       z_q;
  logic       of_q;

  logic       first;
  logic       last;
  logic       accept;
  logic       sub_now;
  logic       bin;
  logic       cin;
  logic [7:0] bop;
  logic [8:0] sum;
  logic       nbrw;
  logic       dz;
  logic       ovf;

  assign s.in_ready = !ov_q || s.out_ready;
  assign accept     = s.in_valid && s.in_ready;
  assign first      = (idx == '0);
  assign last       = (idx == IW'(WORD_BYTES - 1));

  // borrow register holds carry instead when adding
  always_comb begin
    sub_now = 1'b1;
`ifdef SERIAL_ADDSUB_MODE_EN
    sub_now = first ? s.subtract : sub_q;
`endif
    bin  = first ? s.borrow_in : brw;
    cin  = sub_now ? ~bin : bin;
    bop  = sub_now ? ~s.b : s.b;
    sum  = {1'b0, s.a} + {1'b0, bop} + {8'd0, cin};
    nbrw = sub_now ? ~sum[8] : sum[8];
    dz   = (sum[7:0] == 8'd0);
    ovf  = (s.a[7] == bop[7]) && (sum[7] != s.a[7]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      brw  <= 1'b0;
      zacc <= 1'b1;
    end else if (accept) begin
      idx  <= last ? '0 : idx + 1'b1;
      brw  <= last ? 1'b0 : nbrw;
      zacc <= last ? 1'b1 : (zacc & dz);
    end
  end

`ifdef SERIAL_ADDSUB_MODE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sub_q <= 1'b1;
    else if (accept)
      sub_q <= sub_now;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_q   <= 1'b0;
      d_q    <= 8'd0;
      last_q <= 1'b0;
      bo_q   <= 1'b0;
      z_q    <= 1'b0;
      of_q   <= 1'b0;
    end else if (accept) begin
      ov_q   <= 1'b1;
      d_q    <= sum[7:0];
      last_q <= last;
      bo_q   <= last & nbrw;
      z_q    <= last & zacc & dz;
      of_q   <= last & ovf;
    end else if (s.out_ready) begin
      ov_q   <= 1'b0;
    end
  end

  assign s.out_valid  = ov_q;
  assign s.difference = d_q;
  assign s.out_last   = last_q;
  assign s.borrow_out = bo_q;
  assign s.zero       = z_q;
  assign s.overflow   = of_q;

endmodule

// File: tb/tb_serial_byte_subtractor.sv
// Directed checks for serial_byte_subtractor, WORD_BYTES=4.
// Expected results are hand-computed 32-bit differences and flags.
module tb_serial_byte_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  serial_byte_subtractor_if bus ();

  serial_byte_subtractor #(.WORD_BYTES(4)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] av, input logic [7:0] bv,
                       input logic bin);
    bus.in_valid  = 1'b1;
    bus.a         = av;
    bus.b         = bv;
    bus.borrow_in = bin;
  endtask

  task automatic chk_byte(input string tag, input logic [7:0] ed,
                          input bit lst, input logic ebo,
                          input logic ez, input logic eov);
    chk({tag, "_v"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_d"}, 32'(bus.difference), 32'(ed));
    chk({tag, "_l"}, 32'(bus.out_last), 32'(lst));
    chk({tag, "_bo"}, 32'(bus.borrow_out), lst ? 32'(ebo) : 32'd0);
    chk({tag, "_z"}, 32'(bus.zero), lst ? 32'(ez) : 32'd0);
    chk({tag, "_ov"}, 32'(bus.overflow), lst ? 32'(eov) : 32'd0);
  endtask

  // later bytes get the inverted borrow_in, which must be ignored
  task automatic run_op(input string tag, input logic [31:0] av,
                        input logic [31:0] bv, input logic bin,
                        input logic [31:0] ed, input logic ebo,
                        input logic ez, input logic eov);
    for (int i = 0; i < 4; i++) begin
      drive(av[8*i +: 8], bv[8*i +: 8], (i == 0) ? bin : ~bin);
      @(posedge clk); #1;
      chk_byte($sformatf("%s_b%0d", tag, i), ed[8*i +: 8],
               (i == 3), ebo, ez, eov);
    end
  endtask

  initial begin
    logic [31:0] bp_a;
    logic [31:0] bp_b;
    logic [31:0] bp_d;
    bus.in_valid  = 1'b0;
    bus.a         = 8'd0;
    bus.b         = 8'd0;
    bus.borrow_in = 1'b0;
    bus.out_ready = 1'b1;
`ifdef SERIAL_ADDSUB_MODE_EN
    bus.subtract  = 1'b1;
`endif
    #12;
    chk("rst_v", 32'(bus.out_valid), 32'd0);
    chk("rst_d", 32'(bus.difference), 32'd0);
    chk("rst_flags", {28'd0, bus.out_last, bus.borrow_out,
                      bus.zero, bus.overflow}, 32'd0);
    chk("rst_rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // back-to-back operations at one byte per cycle
    run_op("t1", 32'h0000_0005, 32'h0000_0003, 1'b0,
           32'h0000_0002, 1'b0, 1'b0, 1'b0);
    run_op("t2", 32'h0000_0000, 32'h0000_0001, 1'b0,
           32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op("t3", 32'h8000_0000, 32'h0000_0001, 1'b0,
           32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
    run_op("t4", 32'h1234_5678, 32'h1234_5677, 1'b1,
           32'h0000_0000, 1'b0, 1'b1, 1'b0);
    run_op("t5", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0,
           32'h8000_0000, 1'b1, 1'b0, 1'b1);

    // backpressure after byte 0
    bp_a = 32'h0000_0005;
    bp_b = 32'h0000_0003;
    bp_d = 32'h0000_0002;
    for (int i = 0; i < 4; i++) begin
      drive(bp_a[8*i +: 8], bp_b[8*i +: 8], 1'b0);
      if (i == 1) begin
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          #1;
          chk($sformatf("bp_rdy%0d", k), 32'(bus.in_ready), 32'd0);
          @(posedge clk); #1;
          chk($sformatf("bp_hold_d%0d", k), 32'(bus.difference),
              32'h02);
          chk($sformatf("bp_hold_v%0d", k), 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_rdy_up", 32'(bus.in_ready), 32'd1);
      end
      @(posedge clk); #1;
      chk_byte($sformatf("bp_b%0d", i), bp_d[8*i +: 8],
               (i == 3), 1'b0, 1'b0, 1'b0);
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain_v", 32'(bus.out_valid), 32'd0);
    chk("drain_l", 32'(bus.out_last), 32'd1);

    // reset mid-operation with a pending borrow
    for (int i = 0; i < 2; i++) begin
      drive(8'h00, (i == 0) ? 8'h01 : 8'h00, 1'b0);
      @(posedge clk); #1;
    end
    chk("pre_rst_d", 32'(bus.difference), 32'hFF);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("mid_rst_v", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_d", 32'(bus.difference), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op("t6", 32'h0000_0001, 32'h0000_0001, 1'b0,
           32'h0000_0000, 1'b0, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
